// File: rtl/vending_pkg.sv
// vending_pkg: coin encodings and values, plus the dispenser state type,
// shared by the change_dispenser block and its coin_selector.
package vending_pkg;
  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [4:0] VAL_1   = 5'd1;
  localparam logic [4:0] VAL_5   = 5'd5;
  localparam logic [4:0] VAL_10  = 5'd10;
  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} disp_state_e;
  function automatic logic [4:0] coin_value(input logic [1:0] sel);
    return sel == COIN_10 ? VAL_10 : sel == COIN_5 ? VAL_5 : VAL_1;
  endfunction
endpackage

// File: rtl/coin_selector.sv
// coin_selector: greedy pick of the largest in-stock coin not exceeding remaining.
module coin_selector
  import vending_pkg::*;
(
  input  logic [4:0] remaining,
  input  logic       has_1,
  input  logic       has_5,
  input  logic       has_10,
  output logic [1:0] sel,
  output logic       found
);
  logic take_1, take_5, take_10;
  always_comb begin
    take_10 = has_10 && remaining >= VAL_10;
    take_5  = has_5 && remaining >= VAL_5;
    take_1  = has_1 && remaining >= VAL_1;
    sel     = take_10 ? COIN_10 : take_5 ? COIN_5 : COIN_1;
    found   = take_10 || take_5 || take_1;
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays change one coin at a time over a req/ack hopper handshake.
// Define CHANGE_STOCK_EN to build per-denomination stock counters and refill.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int STOCK_INIT  = 8,
  parameter int STOCK_W     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] amount,
  input  logic       refill,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic [4:0] shortfall,
  output logic       error
);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 2);
  disp_state_e       state_q, state_d;
  logic [4:0]        remaining_q, remaining_d, shortfall_q, shortfall_d;
  logic [1:0]        sel_q, sel_d, pick;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_d, found, take, has_1, has_5, has_10;
  logic              coin_req_q, busy_q, done_q, error_q;

  assign take = state_q == DISPENSE && coin_ack;

`ifdef CHANGE_STOCK_EN
  logic [STOCK_W-1:0] stock_q [3];
  assign has_1  = stock_q[COIN_1] != '0;
  assign has_5  = stock_q[COIN_5] != '0;
  assign has_10 = stock_q[COIN_10] != '0;
  // refill takes priority over a coincident decrement
  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (reset || refill) stock_q[i] <= STOCK_W'(STOCK_INIT);
      else if (take && sel_q == 2'(i) && stock_q[i] != '0) stock_q[i] <= stock_q[i] - STOCK_W'(1);
`else
  logic unused_refill;
  assign unused_refill = refill ^ (STOCK_INIT < 0) ^ (STOCK_W < 0);
  assign has_1  = 1'b1;
  assign has_5  = 1'b1;
  assign has_10 = 1'b1;
`endif

  coin_selector u_sel (
    .remaining(remaining_q),
    .has_1    (has_1),
    .has_5    (has_5),
    .has_10   (has_10),
    .sel      (pick),
    .found    (found)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    sel_d       = sel_q;
    wait_d      = '0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d     = SELECT;
        remaining_d = amount;
        shortfall_d = '0;
      end
      SELECT: if (remaining_q == '0) state_d = DONE;
      else if (found) begin
        state_d = DISPENSE;
        sel_d   = pick;
      end else begin
        state_d     = DONE;
        shortfall_d = remaining_q;
        err_d       = 1'b1;
      end
      DISPENSE: if (coin_ack) begin
        state_d     = SELECT;
        remaining_d = remaining_q - coin_value(sel_q);
      end else if (wait_q == WAIT_W'(ACK_TIMEOUT)) begin
        state_d     = DONE;
        shortfall_d = remaining_q;
        err_d       = 1'b1;
      end else wait_d = wait_q + WAIT_W'(1);
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      shortfall_q <= '0;
      sel_q       <= COIN_1;
      wait_q      <= '0;
      coin_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      sel_q       <= sel_d;
      wait_q      <= wait_d;
      coin_req_q  <= state_d == DISPENSE;
      busy_q      <= state_d != IDLE;
      done_q      <= state_d == DONE;
      error_q     <= err_d;
    end

  assign coin_req  = coin_req_q;
  assign coin_sel  = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign shortfall = shortfall_q;
  assign error     = error_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench with a hopper model acking after a set latency.
module tb_change_dispenser;
  import vending_pkg::*;
  localparam int ACK_TIMEOUT = 15;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, refill = 1'b0, coin_ack = 1'b0;
  logic [4:0] amount = '0;
  logic       coin_req, busy, done, error;
  logic [1:0] coin_sel, cur_sel;
  logic [4:0] shortfall;
  logic [5:0] r;
  logic [1:0] coin_q [$];
  logic [5:0] res_q [$];
  int checks = 0, passed = 0, cyc = 0;
  int ack_lat = 0, req_cycles = 0, rise_cyc = 0, first_rise = -1;

  change_dispenser #(.STOCK_INIT(8), .STOCK_W(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .amount   (amount),
    .refill   (refill),
    .coin_ack (coin_ack),
    .coin_req (coin_req),
    .coin_sel (coin_sel),
    .busy     (busy),
    .done     (done),
    .shortfall(shortfall),
    .error    (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  // hopper model and scoreboard consumer
  always @(negedge clk) begin
    if (reset) begin
      req_cycles = 0;
      coin_ack = 1'b0;
    end else begin
      if (coin_req) begin
        if (req_cycles == 0) begin
          rise_cyc = cyc;
          if (first_rise < 0) first_rise = cyc;
          cur_sel = coin_q.size() > 0 ? coin_q.pop_front() : 2'd3;
          check("coin_sel", int'(coin_sel), int'(cur_sel));
        end else check("sel_stable", int'(coin_sel), int'(cur_sel));
        coin_ack = ack_lat >= 0 && req_cycles >= ack_lat;
        req_cycles++;
      end else begin
        req_cycles = 0;
        coin_ack = 1'b0;
      end
      if (done) begin
        check("result_pending", res_q.size(), 1);
        r = res_q.size() > 0 ? res_q.pop_front() : 6'h3f;
        check("shortfall", int'(shortfall), int'(r[4:0]));
        check("error", int'(error), int'(r[5]));
        check("coins_left", coin_q.size(), 0);
        check("req_at_done", int'(coin_req), 0);
      end
    end
  end

  task automatic pay(input logic [4:0] amt, input int n, input logic [15:0] seq,
                     input logic [4:0] sf, input logic err, input int lat, input int poke);
    int s, t;
    ack_lat = lat;
    first_rise = -1;
    for (int i = 0; i < n; i++) coin_q.push_back(seq[2*i +: 2]);
    res_q.push_back({err, sf});
    amount = amt;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 300) begin
      if (t == poke) begin
        check("busy_at_poke", int'(busy), 1);
        amount = 5'd31;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else @(negedge clk);
      t++;
    end
    check("done_seen", int'(done), 1);
    if (n > 0) check("first_req", first_rise - s, 2);
    if (lat >= 0) check("done_lat", cyc - s, 2 + n * (lat + 2));
    else check("timeout_lat", cyc - rise_cyc, ACK_TIMEOUT + 1);
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("idle_after", int'(busy), 0);
    check("shortfall_hold", int'(shortfall), int'(sf));
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst_req", int'(coin_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(error), 0);
    check("rst_shortfall", int'(shortfall), 0);
    reset = 1'b0;
    @(negedge clk);
    pay(5'd17, 4, {8'd0, COIN_1, COIN_1, COIN_5, COIN_10}, 5'd0, 1'b0, 0, -1);
    pay(5'd6, 1, {14'd0, COIN_5}, 5'd6, 1'b1, -1, -1);
    pay(5'd0, 0, 16'd0, 5'd0, 1'b0, 0, -1);
    pay(5'd17, 4, {8'd0, COIN_1, COIN_1, COIN_5, COIN_10}, 5'd0, 1'b0, 2, 3);
    pay(5'd23, 5, {6'd0, COIN_1, COIN_1, COIN_1, COIN_10, COIN_10}, 5'd0, 1'b0, 1, -1);
    // reset in the middle of a coin request
    ack_lat = 3;
    coin_q.push_back(COIN_10);
    coin_q.push_back(COIN_10);
    res_q.push_back(6'd0);
    amount = 5'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!coin_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("req_before_reset", int'(coin_req), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req", int'(coin_req), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_sel", int'(coin_sel), 0);
    check("mid_rst_shortfall", int'(shortfall), 0);
    reset = 1'b0;
    coin_q.delete();
    res_q.delete();
    @(negedge clk);
    pay(5'd10, 1, {14'd0, COIN_10}, 5'd0, 1'b0, 0, -1);
`ifdef CHANGE_STOCK_EN
    pay(5'd30, 3, {10'd0, COIN_10, COIN_10, COIN_10}, 5'd0, 1'b0, 0, -1);
    pay(5'd30, 3, {10'd0, COIN_10, COIN_10, COIN_10}, 5'd0, 1'b0, 0, -1);
    pay(5'd10, 1, {14'd0, COIN_10}, 5'd0, 1'b0, 0, -1);
    pay(5'd17, 5, {6'd0, COIN_1, COIN_1, COIN_5, COIN_5, COIN_5}, 5'd0, 1'b0, 0, -1);
    pay(5'd4, 4, {8'd0, COIN_1, COIN_1, COIN_1, COIN_1}, 5'd0, 1'b0, 0, -1);
    pay(5'd2, 2, {12'd0, COIN_1, COIN_1}, 5'd0, 1'b0, 0, -1);
    pay(5'd3, 0, 16'd0, 5'd3, 1'b1, 0, -1);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    pay(5'd17, 4, {8'd0, COIN_1, COIN_1, COIN_5, COIN_10}, 5'd0, 1'b0, 0, -1);
`endif
    repeat (2) @(negedge clk);
    check("sb_empty", res_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential payout engine for the vending machine. It takes the change amount produced at the end of a transaction and pays it out one coin at a time through a coin hopper, using a request/acknowledge handshake. It picks coins greedily from 10/5/1-unit denominations, can optionally track hopper stock, and reports any amount it could not pay as a shortfall. It sits between the change calculation stage and the physical hopper interface.

## Interface
Parameters:
- `STOCK_INIT`, default 8: coins per denomination loaded at reset and on `refill`.
- `STOCK_W`, default 4: width of each stock counter. Must satisfy `STOCK_INIT < 2**STOCK_W`.
- `ACK_TIMEOUT`, default 15: maximum cycles to wait for `coin_ack` before aborting.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that loads `amount`. Ignored unless the block is idle.
- `amount`, in, 5: change to pay, 0..31 units.
- `refill`, in, 1: reload all stocks to `STOCK_INIT`.
- `coin_ack`, in, 1: the hopper has released the requested coin.
- `coin_req`, out, 1: a coin is requested. Held until ack or timeout.
- `coin_sel`, out, 2: requested denomination. 2'd0 = 1 unit, 2'd1 = 5, 2'd2 = 10.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse when a payout ends.
- `shortfall`, out, 5: unpaid remainder. Valid while `done` is high and held until the next `start`.
- `error`, out, 1: pulses with `done` if `shortfall != 0` or a timeout occurred.

## Operation
- FSM states: IDLE, SELECT, DISPENSE, DONE. All outputs are registered.
- **IDLE**:
  - On `start`, latch `amount` into `remaining`, clear `shortfall`, go to SELECT.
- **SELECT**:
  - If `remaining == 0`, go to DONE with no error.
  - Otherwise pick the largest denomination whose value is ≤ `remaining` and whose stock is > 0, drive it on `coin_sel`, and go to DISPENSE.
  - If no denomination qualifies, set `shortfall = remaining` and go to DONE with `error`.
- **DISPENSE**:
  - `coin_req` = 1 and `coin_sel` is held stable.
  - On `coin_ack`: `remaining -= value`, decrement that denomination's stock, go to SELECT.
  - A wait counter increments each cycle without ack. When it reaches `ACK_TIMEOUT`: `shortfall = remaining`, go to DONE with `error`. No stock is decremented.
- **DONE**: `done` = 1 (and `error` if applicable) for exactly one cycle, then IDLE.
- Arithmetic:
  - `remaining` is 5-bit and never underflows, because only values ≤ `remaining` are selected.
  - Stock counters saturate at 0.
- `coin_ack` is ignored outside DISPENSE.
- `refill`:
  - When `refill` coincides with a stock decrement, `refill` wins.
  - `refill` is accepted in any state. A new stock value is first seen by the next SELECT.
- `reset` at any point, including mid-DISPENSE:
  - Next state IDLE; `coin_req`, `done`, `error`, `busy` = 0.
  - `coin_sel` = 0, `shortfall` = 0, `remaining` = 0.
  - All stocks = `STOCK_INIT`.

## Timing
- `start` sampled at edge k: SELECT during cycle k+1, `coin_req` high from cycle k+2.
- `coin_ack` sampled at edge m: `coin_req` low in cycle m+1 (SELECT), next `coin_req` in cycle m+2.
- If `coin_ack` is already high in the first cycle of `coin_req`, that counts as the acknowledgement.
- `amount = 0`: `done` pulses in cycle k+2, no coins requested.
- Per-coin cost: 2 cycles plus hopper latency.
- Timeout:
  - `done` is raised `ACK_TIMEOUT` + 1 cycles after `coin_req` rises.
  - `coin_req` falls in the same cycle `done` rises.

## Configuration
- `CHANGE_STOCK_EN` defined:
  - Stock counters, `refill`, and stock-based fallback to smaller coins are present.
  - Shortfall is possible from empty stock.
- `CHANGE_STOCK_EN` undefined:
  - Stock is treated as infinite; no counters are built.
  - `refill` is ignored.
  - Shortfall is possible only from timeout.

## Structure
- Shared package `vending_pkg`:
  - `coin_sel` encodings: `COIN_1`, `COIN_5`, `COIN_10`.
  - Coin value constants.
  - Dispenser state enum typedef.
- Sub-module `coin_selector`: combinational. Inputs are `remaining` and the three stock-nonzero flags. Outputs are `sel` and `found`. Instantiated once, in SELECT logic.

## Test plan
- `amount = 17`, immediate acks → coins 10, 5, 1, 1 in order; `done` with `shortfall = 0`, `error = 0`; 10-stock = 7, 5-stock = 7, 1-stock = 6.
- `CHANGE_STOCK_EN`, 10-stock drained to 0, `amount = 17` → coins 5, 5, 5, 1, 1; no error.
- 1-stock = 0, `amount = 3` → no `coin_req`; `done` + `error`, `shortfall = 3`.
- `amount = 6`, first ack withheld → `done` + `error` 16 cycles after `coin_req` rises, `shortfall = 6`; 5-stock unchanged.
- `amount = 0` → `done` two cycles after `start`, no coins; `start` while `busy` → ignored and the current payout completes unchanged.
- `reset` asserted during DISPENSE of `amount = 20` → next cycle `coin_req = 0`, `busy = 0`, stocks back to 8; a following `start` with `amount = 10` pays one 10-unit coin.
